// File: rtl/ex_stage.sv
// Execute stage: logic/shift/arith ALU, single-cycle multiply into HI/LO,
// and an iterative restoring divider that stalls upstream while it runs.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ex_alusel,
    input  logic [4:0]  ex_aluop,
    input  logic [31:0] ex_srcLeft,
    input  logic [31:0] ex_srcRight,
    input  logic [31:0] ex_offset,
    input  logic [3:0]  ex_memop,
    input  logic [4:0]  ex_dest,
    input  logic        ex_writeEnable,
    output logic        stall_req,
    output logic [31:0] mem_result,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_storeData,
    output logic [3:0]  mem_memop,
    output logic [4:0]  mem_dest,
    output logic        mem_writeEnable,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int W  = 32;
    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_ARITH = 3'd3, SEL_MULDIV = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_DONE} state_t;

    state_t r_state, w_next;

    logic signed [W-1:0] w_a_s, w_b_s;
    logic [W-1:0]        w_result;
    logic [2*W-1:0]      w_prod;
    logic                w_is_mult, w_is_div, w_div_signed, w_dvsr_zero;
    logic [W-1:0]        w_a_abs, w_b_abs;

    logic [W-1:0]  r_quo, r_rem, r_dvsr;
    logic          r_qneg, r_rneg;
    logic [CW-1:0] r_cnt;
    logic [W:0]    w_rem_sh;
    logic          w_ge;
    logic [W-1:0]  w_sub, w_quo_fin, w_rem_fin;

    assign w_a_s        = ex_srcLeft;
    assign w_b_s        = ex_srcRight;
    assign w_is_mult    = (ex_alusel == SEL_MULDIV) && (ex_aluop == 5'd0 || ex_aluop == 5'd1);
    assign w_is_div     = (ex_alusel == SEL_MULDIV) && (ex_aluop == 5'd2 || ex_aluop == 5'd3);
    assign w_div_signed = (ex_aluop == 5'd2);
    assign w_dvsr_zero  = (ex_srcRight == '0);

    assign w_prod = (ex_aluop == 5'd0)
                  ? ({{W{ex_srcLeft[W-1]}}, ex_srcLeft} * {{W{ex_srcRight[W-1]}}, ex_srcRight})
                  : ({{W{1'b0}}, ex_srcLeft} * {{W{1'b0}}, ex_srcRight});

    always_comb begin
        w_result = '0;
        case (ex_alusel)
            SEL_LOGIC: case (ex_aluop)
                5'd0:    w_result = ex_srcLeft & ex_srcRight;
                5'd1:    w_result = ex_srcLeft | ex_srcRight;
                5'd2:    w_result = ex_srcLeft ^ ex_srcRight;
                5'd3:    w_result = ~(ex_srcLeft | ex_srcRight);
                5'd4:    w_result = {ex_srcRight[15:0], 16'h0000};
                default: w_result = '0;
            endcase
            SEL_SHIFT: case (ex_aluop)
                5'd0:    w_result = ex_srcRight << ex_srcLeft[4:0];
                5'd1:    w_result = ex_srcRight >> ex_srcLeft[4:0];
                5'd2:    w_result = w_b_s >>> ex_srcLeft[4:0];
                default: w_result = '0;
            endcase
            SEL_ARITH: case (ex_aluop)
                5'd0:    w_result = ex_srcLeft + ex_srcRight;
                5'd1:    w_result = ex_srcLeft - ex_srcRight;
                5'd2:    w_result = {{(W-1){1'b0}}, (w_a_s < w_b_s)};
                5'd3:    w_result = {{(W-1){1'b0}}, (ex_srcLeft < ex_srcRight)};
                default: w_result = '0;
            endcase
            SEL_MULDIV: case (ex_aluop)
                5'd4:    w_result = hi_o;
                5'd5:    w_result = lo_o;
                default: w_result = '0;
            endcase
            default: w_result = '0;
        endcase
    end

    // Divider datapath: magnitudes in, one restoring step per BUSY cycle
    assign w_a_abs   = (w_div_signed && ex_srcLeft[W-1])  ? -ex_srcLeft  : ex_srcLeft;
    assign w_b_abs   = (w_div_signed && ex_srcRight[W-1]) ? -ex_srcRight : ex_srcRight;
    assign w_rem_sh  = {r_rem, r_quo[W-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
    assign w_sub     = w_rem_sh[W-1:0] - r_dvsr;
    assign w_quo_fin = r_qneg ? -r_quo : r_quo;
    assign w_rem_fin = r_rneg ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_is_div && !w_dvsr_zero) w_next = S_LOAD;
            S_LOAD: w_next = S_BUSY;
            S_BUSY: if (r_cnt == CNT_LAST) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_req = 1'b0;
        case (r_state)
            S_IDLE:  stall_req = w_is_div && !w_dvsr_zero;
            S_LOAD:  stall_req = 1'b1;
            S_BUSY:  stall_req = 1'b1;
            default: stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_LOAD: begin
                r_quo  <= w_a_abs;
                r_rem  <= '0;
                r_dvsr <= w_b_abs;
                r_qneg <= w_div_signed && (ex_srcLeft[W-1] ^ ex_srcRight[W-1]);
                r_rneg <= w_div_signed && ex_srcLeft[W-1];
                r_cnt  <= '0;
            end
            S_BUSY: begin
                r_rem <= w_ge ? w_sub : w_rem_sh[W-1:0];
                r_quo <= {r_quo[W-2:0], w_ge};
                r_cnt <= r_cnt + CW'(1);
            end
            default: ;
        endcase
    end

    // EX/MEM boundary and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_result      <= '0;
            mem_addr        <= '0;
            mem_storeData   <= '0;
            mem_memop       <= '0;
            mem_dest        <= '0;
            mem_writeEnable <= 1'b0;
            hi_o            <= '0;
            lo_o            <= '0;
        end else begin
            if (stall_req) begin
                mem_result      <= '0;
                mem_addr        <= '0;
                mem_storeData   <= '0;
                mem_memop       <= '0;
                mem_dest        <= '0;
                mem_writeEnable <= 1'b0;
            end else begin
                mem_result      <= w_result;
                mem_addr        <= ex_srcLeft + ex_offset;
                mem_storeData   <= ex_srcRight;
                mem_memop       <= ex_memop;
                mem_dest        <= ex_dest;
                mem_writeEnable <= ex_writeEnable && !w_is_div;
            end
            if (r_state == S_DONE) begin
                hi_o <= w_rem_fin;
                lo_o <= w_quo_fin;
            end else if (r_state == S_IDLE && w_is_mult) begin
                {hi_o, lo_o} <= w_prod;
            end else if (r_state == S_IDLE && w_is_div && w_dvsr_zero) begin
                hi_o <= ex_srcLeft;
                lo_o <= '1;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model of HI/LO and the ALU.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_aluop;
    logic [31:0] ex_srcLeft, ex_srcRight, ex_offset;
    logic [3:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;
    logic        stall_req;
    logic [31:0] mem_result, mem_addr, mem_storeData;
    logic [3:0]  mem_memop;
    logic [4:0]  mem_dest;
    logic        mem_writeEnable;
    logic [31:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
        .ex_srcLeft(ex_srcLeft), .ex_srcRight(ex_srcRight), .ex_offset(ex_offset),
        .ex_memop(ex_memop), .ex_dest(ex_dest), .ex_writeEnable(ex_writeEnable),
        .stall_req(stall_req),
        .mem_result(mem_result), .mem_addr(mem_addr), .mem_storeData(mem_storeData),
        .mem_memop(mem_memop), .mem_dest(mem_dest), .mem_writeEnable(mem_writeEnable),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] sel, input logic [4:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(a[4:0]);
        r = 0;
        case (sel)
            3'd1: case (op)
                5'd0: r = a & b;
                5'd1: r = a | b;
                5'd2: r = a ^ b;
                5'd3: r = ~(a | b);
                5'd4: r = {b[15:0], 16'h0};
                default: r = 0;
            endcase
            3'd2: case (op)
                5'd0: r = b << sh;
                5'd1: r = b >> sh;
                5'd2: begin
                    r = b >> sh;
                    if (b[31]) r = r | ~(32'hFFFFFFFF >> sh);
                end
                default: r = 0;
            endcase
            3'd3: case (op)
                5'd0: r = a + b;
                5'd1: r = a - b;
                5'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                5'd3: r = (a < b) ? 32'd1 : 32'd0;
                default: r = 0;
            endcase
            3'd4: case (op)
                5'd4: r = m_hi;
                5'd5: r = m_lo;
                default: r = 0;
            endcase
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic do_op(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] off, input logic [3:0] mop,
                         input logic [4:0] dst, input logic we);
        logic [31:0] e_res;
        logic        is_div, launch;
        longint      q, r;
        longint unsigned p;
        int stalls, bad;
        @(negedge clk);
        ex_alusel = sel; ex_aluop = op; ex_srcLeft = a; ex_srcRight = b;
        ex_offset = off; ex_memop = mop; ex_dest = dst; ex_writeEnable = we;
        e_res  = model_res(sel, op, a, b);
        is_div = (sel == 3'd4) && (op == 5'd2 || op == 5'd3);
        launch = is_div && (b != 0);
        #1;
        chk("stall_comb", 32'(stall_req), 32'(launch));
        if (launch) begin
            stalls = 0; bad = 0;
            while (stall_req && stalls < 100) begin
                @(posedge clk); #1;
                stalls++;
                if (mem_writeEnable !== 1'b0 || mem_memop !== 4'd0 || mem_dest !== 5'd0 || mem_result !== 32'd0)
                    bad++;
            end
            chk("div_stall_cycles", stalls, 34);
            chk("div_bubbles_bad", bad, 0);
        end
        @(posedge clk); #1;
        if (sel == 3'd4 && op == 5'd0) begin
            p = longint'(int'(a)) * longint'(int'(b));
            m_hi = p[63:32]; m_lo = p[31:0];
        end else if (sel == 3'd4 && op == 5'd1) begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            m_hi = p[63:32]; m_lo = p[31:0];
        end else if (is_div && b == 0) begin
            m_hi = a; m_lo = 32'hFFFFFFFF;
        end else if (is_div && op == 5'd2) begin
            q = longint'(int'(a)) / longint'(int'(b));
            r = longint'(int'(a)) % longint'(int'(b));
            m_lo = q[31:0]; m_hi = r[31:0];
        end else if (is_div) begin
            m_lo = a / b; m_hi = a % b;
        end
        chk("result", mem_result, e_res);
        chk("addr", mem_addr, a + off);
        chk("storeData", mem_storeData, b);
        chk("memop", 32'(mem_memop), 32'(mop));
        chk("dest", 32'(mem_dest), 32'(dst));
        chk("we", 32'(mem_writeEnable), 32'(we && !is_div));
        chk("hi", hi_o, m_hi);
        chk("lo", lo_o, m_lo);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h80000000;
            1: v = 32'hFFFFFFFF;
            2: v = 32'd0;
            3: v = 32'(32'($urandom_range(0, 40)) - 32'd20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        ex_alusel = 0; ex_aluop = 0; ex_srcLeft = 0; ex_srcRight = 0;
        ex_offset = 0; ex_memop = 0; ex_dest = 0; ex_writeEnable = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", mem_result, 0);
        chk("rst_we", 32'(mem_writeEnable), 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_stall", 32'(stall_req), 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(3'd1, 5'd1, 32'h0000F0F0, 32'h00000F0F, 32'd8, 4'd1, 5'd5, 1'b1);
        do_op(3'd2, 5'd2, 32'd4, 32'h80000000, 32'd0, 4'd1, 5'd6, 1'b1);
        do_op(3'd2, 5'd2, 32'd0, 32'h80000001, 32'd0, 4'd1, 5'd6, 1'b1);
        do_op(3'd3, 5'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd1, 5'd7, 1'b1);
        do_op(3'd3, 5'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd1, 5'd7, 1'b1);
        do_op(3'd4, 5'd0, 32'hFFFFFFFE, 32'd3, 32'd0, 4'd0, 5'd0, 1'b0);
        do_op(3'd4, 5'd4, 32'd0, 32'd0, 32'd0, 4'd1, 5'd8, 1'b1);
        do_op(3'd4, 5'd5, 32'd0, 32'd0, 32'd0, 4'd1, 5'd9, 1'b1);
        do_op(3'd4, 5'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 4'd0, 5'd3, 1'b1);
        do_op(3'd4, 5'd5, 32'd0, 32'd0, 32'd0, 4'd1, 5'd9, 1'b1);
        do_op(3'd4, 5'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 4'd0, 5'd0, 1'b0);
        do_op(3'd4, 5'd3, 32'd100, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0);
        do_op(3'd1, 5'd1, 32'd1, 32'd2, 32'd0, 4'd1, 5'd0, 1'b1);

        // Reset ten iterations into a DIVU
        @(negedge clk);
        ex_alusel = 3'd4; ex_aluop = 5'd3; ex_srcLeft = 32'd1000; ex_srcRight = 32'd7;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ex_alusel = 0; ex_aluop = 0; ex_srcLeft = 0; ex_srcRight = 0;
        ex_offset = 0; ex_memop = 0; ex_dest = 0; ex_writeEnable = 0;
        @(posedge clk); #1;
        m_hi = 0; m_lo = 0;
        chk("rstdiv_stall", 32'(stall_req), 0);
        chk("rstdiv_hi", hi_o, 0);
        chk("rstdiv_lo", lo_o, 0);
        chk("rstdiv_result", mem_result, 0);
        chk("rstdiv_addr", mem_addr, 0);
        chk("rstdiv_memop", 32'(mem_memop), 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(3'd3, 5'd0, 32'd2, 32'd3, 32'd0, 4'd1, 5'd4, 1'b1);

        for (int i = 0; i < 300; i++) begin
            do_op(3'($urandom_range(0, 5)), 5'($urandom_range(0, 7)), rnd_word(), rnd_word(),
                  $urandom, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
